calc_id_gm_seq: RTL and testbench
=================================

CALC_ID_GM_SEQ -- requirements
Module: calc_id_gm_seq

Interface
REQ-001 SHALL have parameter W_BITS, default 3: width of v_gs, v_ds and w, range 2..8.
REQ-002 SHALL have parameter N_DEV, default 6: devices per group, range 2..64.
REQ-003 SHALL define derived widths:
  - RES_W = 3*W_BITS+1.
  - SUM_W = RES_W + clog2(N_DEV).
  - IDX_W = max(1, clog2(N_DEV)).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mode  in  1  1 = drain current ID, 0 = transconductance gm; sampled on the first beat of a group only.
REQ-007 v_gs, v_ds, w  in  W_BITS each  unsigned device operands.
REQ-008 in_valid  in  1 / in_ready  out  1  input handshake; a beat transfers on an edge where both are high.
REQ-009 out_valid  out  1 / out_ready  in  1  output handshake.
REQ-010 out_max  out  RES_W  largest per-device result in the group.
REQ-011 out_idx  out  IDX_W  index (0-based beat order) of out_max.
REQ-012 out_sum  out  SUM_W  sum of all per-device results.
REQ-013 out_mode  out  1  latched group mode.

Function
REQ-014 Per-device result SHALL be computed with g = v_gs-1, using floor division by 3 and no overflow at any width.
REQ-015 If v_gs == 0 (cutoff), the result SHALL be 0.
REQ-016 If g > v_ds (triode):
  - ID = floor(w*(2*g*v_ds - v_ds^2)/3).
  - gm = floor(2*w*v_ds/3).
REQ-017 Otherwise (saturation):
  - ID = floor(w*g*g/3).
  - gm = floor(2*w*g/3).
REQ-018 FSM states SHALL be IDLE, ACCUM, DRAIN, DONE.
REQ-019 IDLE:
  - in_ready=1.
  - A beat latches mode into out_mode, sets beat count to 1, goes to ACCUM.
  - If N_DEV beats are already reached, goes to DRAIN instead.
REQ-020 ACCUM:
  - in_ready=1; each beat increments the count.
  - The beat making count == N_DEV moves to DRAIN.
  - The mode input is ignored in this state.
REQ-021 DRAIN: in_ready=0; SHALL move to DONE when the last device's result has been accumulated.
REQ-022 Pipeline SHALL be two register stages:
  - S1 registers the undivided product plus the region/cutoff flags.
  - S2 divides by 3 and updates the running max, index and sum.
REQ-023 out_valid SHALL rise after the 2nd edge following the edge accepting the last beat.
REQ-024 Max update SHALL occur only when the new result is strictly greater than the running max; ties keep the lower index.
REQ-025 DONE:
  - out_valid=1 and in_ready=0.
  - out_max, out_idx, out_sum and out_mode SHALL hold stable until out_ready=1.
  - On that edge: go to IDLE, clear the accumulators, deassert out_valid.
REQ-026 No beat SHALL be accepted in the edge where DONE is consumed; next acceptance is possible one cycle later.
REQ-027 in_valid held high while in_ready=0 SHALL have no effect; pipeline bubbles (in_valid=0 mid-group) SHALL be tolerated with no result loss.

Reset
REQ-028 On rst=1 at an edge:
  - FSM goes to IDLE and all pipeline valids clear.
  - out_valid=0, out_max=0, out_idx=0, out_sum=0, out_mode=0.
  - Beat count clears to 0.
REQ-029 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-group or in DONE SHALL discard the partial group entirely; no out_valid SHALL follow from it.

Verification
REQ-031 N_DEV=3, W_BITS=3, mode=1, devices (5,2,3), (3,5,7), (7,7,7) -> out_max=84, out_idx=2, out_sum=105, out_mode=1.
REQ-032 Same devices with mode=0 on the first beat, and mode toggled on later beats -> out_max=28, out_idx=2, out_sum=41, out_mode=0.
REQ-033 N_DEV=3, mode=1, devices (0,3,7), (1,0,7), (2,5,1) -> per-device results 0, 0, 0; out_max=0, out_idx=0, out_sum=0.
REQ-034 N_DEV=3, mode=1, devices (7,7,7) x3 -> out_max=84, out_idx=0, out_sum=252; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-035 Two devices accepted, then rst pulsed one cycle, then a fresh group (5,2,3) x3 with mode=1 -> single out_valid with out_sum=36, out_max=12, out_idx=0.
REQ-036 Back-to-back groups with in_valid stuck at 1 and random bubbles -> each group's outputs match a reference model; no beat is lost or double-counted.

Source files
------------

// File: rtl/calc_id_gm_seq.sv
// calc_id_gm_seq
// Streams a group of N_DEV square-law transistor devices, one device per beat.
// For each device it computes either the drain current ID or the
// transconductance gm (selected once per group). It then reports the largest
// per-device result, the beat index of that result, and the sum of all results.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   mode                      1 = drain current ID, 0 = gm (sampled on first beat)
//   v_gs, v_ds, w             unsigned device operands, W_BITS each
//   in_valid / in_ready       input beat handshake
//   out_valid / out_ready     group result handshake
//   out_max, out_idx          largest result and its 0-based beat index
//   out_sum                   sum of all results in the group
//   out_mode                  mode latched for the group
module calc_id_gm_seq #(
    parameter  int W_BITS = 3,
    parameter  int N_DEV  = 6,
    localparam int RES_W  = 3 * W_BITS + 1,
    localparam int SUM_W  = RES_W + $clog2(N_DEV),
    localparam int IDX_W  = ($clog2(N_DEV) > 1) ? $clog2(N_DEV) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [W_BITS-1:0] v_gs,
    input  logic [W_BITS-1:0] v_ds,
    input  logic [W_BITS-1:0] w,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [SUM_W-1:0]  out_sum,
    output logic              out_mode
);

    localparam int CNT_W = $clog2(N_DEV + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [RES_W-1:0]   r_max;
    logic [IDX_W-1:0]   r_idx;
    logic [SUM_W-1:0]   r_sum;
    logic               r_out_mode;

    // Floor division by 3 of a non-negative product.
    function automatic logic [RES_W-1:0] div3(input logic [RES_W-1:0] x);
        return x / RES_W'(3);
    endfunction

    logic               w_accept;
    logic               w_last;
    logic               w_mode_eff;
    logic [W_BITS-1:0]  w_g_n;
    logic               w_cut;
    logic               w_tri;
    logic [RES_W-1:0]   w_g;
    logic [RES_W-1:0]   w_vds;
    logic [RES_W-1:0]   w_wd;
    logic [RES_W-1:0]   w_id_tri;
    logic [RES_W-1:0]   w_id_sat;
    logic [RES_W-1:0]   w_gm_tri;
    logic [RES_W-1:0]   w_gm_sat;
    logic [RES_W-1:0]   w_prod;
    logic [RES_W-1:0]   w_res;

    // Gating with rst keeps in_ready low during the reset cycle itself.
    assign in_ready   = !rst && ((r_state == IDLE) || (r_state == ACCUM));
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_cnt == CNT_W'(N_DEV - 1));
    // The first beat uses the live mode; later beats use the latched one.
    assign w_mode_eff = (r_state == IDLE) ? mode : r_out_mode;

    assign w_g_n = v_gs - W_BITS'(1);
    assign w_cut = (v_gs == '0);
    assign w_tri = !w_cut && (w_g_n > v_ds);
    assign w_g   = RES_W'(w_g_n);
    assign w_vds = RES_W'(v_ds);
    assign w_wd  = RES_W'(w);

    // All products are bounded by w*g^2 < 2^(3*W_BITS), so RES_W never
    // overflows. In triode g > v_ds, so 2g - v_ds stays positive.
    assign w_id_tri = w_wd * w_vds * ((w_g << 1) - w_vds);
    assign w_id_sat = w_wd * w_g * w_g;
    assign w_gm_tri = (w_wd * w_vds) << 1;
    assign w_gm_sat = (w_wd * w_g) << 1;

    always_comb begin
        w_prod = '0;
        if (w_mode_eff) w_prod = w_tri ? w_id_tri : w_id_sat;
        else            w_prod = w_tri ? w_gm_tri : w_gm_sat;
    end

    // ---- Stage 1: undivided product, cutoff flag, beat index ----
    logic               r_vld_p1;
    logic               r_last_p1;
    logic [RES_W-1:0]   r_prod_p1;
    logic               r_cut_p1;
    logic [IDX_W-1:0]   r_idx_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else begin
            r_vld_p1  <= w_accept;
            r_last_p1 <= w_accept && w_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_prod_p1 <= w_prod;
            r_cut_p1  <= w_cut;
            r_idx_p1  <= r_cnt[IDX_W-1:0];
        end
    end

    // ---- Stage 2: divide, running max/index/sum, FSM ----
    logic r_last_p2;

    assign w_res = r_cut_p1 ? '0 : div3(r_prod_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last_p2   <= 1'b0;
            r_out_valid <= 1'b0;
            r_max       <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_out_mode  <= 1'b0;
        end else begin
            r_last_p2 <= r_vld_p1 && r_last_p1;

            if (r_vld_p1) begin
                r_sum <= r_sum + SUM_W'(w_res);
                // Strictly greater: ties keep the earlier beat.
                if (w_res > r_max) begin
                    r_max <= w_res;
                    r_idx <= r_idx_p1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_out_mode <= mode;
                        r_cnt      <= CNT_W'(1);
                        r_state    <= w_last ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last device's result has just been folded in.
                    if (r_last_p2) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_max       <= '0;
                        r_idx       <= '0;
                        r_sum       <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_max   = r_max;
    assign out_idx   = r_idx;
    assign out_sum   = r_sum;
    assign out_mode  = r_out_mode;

endmodule

// File: tb/tb_calc_id_gm_seq.sv
// Directed bench for calc_id_gm_seq with N_DEV=3, W_BITS=3: vector table of
// whole groups, a stall/hold sequence, reset mid-group, and back-to-back
// groups with in_valid held high and random bubbles against a small model.
module tb_calc_id_gm_seq;

    localparam int W     = 3;
    localparam int N     = 3;
    localparam int RES_W = 10;
    localparam int SUM_W = 12;
    localparam int IDX_W = 2;
    localparam int NG    = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [W-1:0]     v_gs, v_ds, w;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_max;
    logic [IDX_W-1:0] out_idx;
    logic [SUM_W-1:0] out_sum;
    logic             out_mode;

    calc_id_gm_seq #(.W_BITS(W), .N_DEV(N)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .v_gs(v_gs), .v_ds(v_ds), .w(w),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_idx(out_idx), .out_sum(out_sum),
        .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    typedef struct {
        logic            m0;
        logic            ml;
        logic [2:0][2:0] g;
        logic [2:0][2:0] d;
        logic [2:0][2:0] ww;
        int              e_max;
        int              e_idx;
        int              e_sum;
    } vec_t;

    function automatic vec_t mk(input logic m0, input logic ml,
                                input logic [2:0] g0, d0, w0, g1, d1, w1, g2, d2, w2,
                                input int emax, input int eidx, input int esum);
        vec_t v;
        v.m0 = m0; v.ml = ml;
        v.g[0] = g0; v.d[0] = d0; v.ww[0] = w0;
        v.g[1] = g1; v.d[1] = d1; v.ww[1] = w1;
        v.g[2] = g2; v.d[2] = d2; v.ww[2] = w2;
        v.e_max = emax; v.e_idx = eidx; v.e_sum = esum;
        return v;
    endfunction

    // Independent per-device reference.
    function automatic int model(input logic m, input int g, input int d, input int ww);
        int gg;
        if (g == 0) return 0;
        gg = g - 1;
        if (gg > d) return m ? (ww * (2 * gg * d - d * d)) / 3 : (2 * ww * d) / 3;
        return m ? (ww * gg * gg) / 3 : (2 * ww * gg) / 3;
    endfunction

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic send_beat(input logic m, input logic [2:0] g, d, ww);
        logic ok;
        mode = m; v_gs = g; v_ds = d; w = ww; in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) return;
        end
        timeout_fail("beat_accept");
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) timeout_fail("out_valid_wait");
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consume_out_valid", out_valid, 0);
        check("consume_sum_clear", out_sum, 0);
        check("consume_in_ready", in_ready, 1);
    endtask

    vec_t tv[6];
    int   lat;
    logic seen;

    int   rg [NG*N], rd [NG*N], rw [NG*N];
    logic rm [NG*N];
    int   x_max [NG], x_idx [NG], x_sum [NG];
    logic x_mode [NG];

    initial begin
        rst = 1'b1; mode = 1'b0; v_gs = '0; v_ds = '0; w = '0;
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_max", out_max, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        tv[0] = mk(1, 1, 5,2,3, 3,5,7, 7,7,7, 84, 2, 105);
        tv[1] = mk(0, 1, 5,2,3, 3,5,7, 7,7,7, 28, 2, 41);
        tv[2] = mk(1, 1, 0,3,7, 1,0,7, 2,5,1, 0, 0, 0);
        tv[3] = mk(1, 0, 7,7,7, 7,7,7, 7,7,7, 84, 0, 252);
        tv[4] = mk(0, 1, 7,7,7, 7,7,7, 7,7,7, 28, 0, 84);
        tv[5] = mk(0, 1, 4,1,5, 7,7,7, 4,1,5, 28, 1, 34);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++)
                send_beat((k == 0) ? tv[i].m0 : tv[i].ml, tv[i].g[k], tv[i].d[k], tv[i].ww[k]);
            in_valid = 1'b0;
            wait_out(lat);
            check($sformatf("v%0d_latency", i), lat, 2);
            check($sformatf("v%0d_max", i), out_max, tv[i].e_max);
            check($sformatf("v%0d_idx", i), out_idx, tv[i].e_idx);
            check($sformatf("v%0d_sum", i), out_sum, tv[i].e_sum);
            check($sformatf("v%0d_mode", i), out_mode, tv[i].m0);
            if (i == 3) begin
                in_valid = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    check("stall_out_valid", out_valid, 1);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_max", out_max, 84);
                    check("stall_idx", out_idx, 0);
                    check("stall_sum", out_sum, 252);
                end
                in_valid = 1'b0;
            end
            consume();
        end

        // Reset mid-group discards the partial group
        send_beat(1, 7, 7, 7);
        send_beat(1, 7, 7, 7);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_sum_clear", out_sum, 0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("midrst_no_out_valid", seen, 0);
        for (int k = 0; k < N; k++) send_beat(1, 5, 2, 3);
        in_valid = 1'b0;
        wait_out(lat);
        check("midrst_sum", out_sum, 36);
        check("midrst_max", out_max, 12);
        check("midrst_idx", out_idx, 0);
        consume();

        // Back-to-back groups, in_valid held high, random bubbles and out_ready
        for (int gi = 0; gi < NG; gi++) begin
            x_max[gi] = 0; x_idx[gi] = 0; x_sum[gi] = 0;
            for (int k = 0; k < N; k++) begin
                int b, r;
                b = gi * N + k;
                rg[b] = $urandom_range(0, 7);
                rd[b] = $urandom_range(0, 7);
                rw[b] = $urandom_range(0, 7);
                rm[b] = 1'($urandom_range(0, 1));
                if (k == 0) x_mode[gi] = rm[b];
                r = model(x_mode[gi], rg[b], rd[b], rw[b]);
                x_sum[gi] += r;
                if (r > x_max[gi]) begin
                    x_max[gi] = r;
                    x_idx[gi] = k;
                end
            end
        end

        fork
            begin
                for (int b = 0; b < NG * N; b++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    send_beat(rm[b], 3'(rg[b]), 3'(rd[b]), 3'(rw[b]));
                end
                in_valid = 1'b0;
            end
            begin
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < NG && cyc < 5000) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (out_valid && ($urandom_range(0, 1) == 1)) begin
                        check($sformatf("rnd%0d_max", got), out_max, x_max[got]);
                        check($sformatf("rnd%0d_idx", got), out_idx, x_idx[got]);
                        check($sformatf("rnd%0d_sum", got), out_sum, x_sum[got]);
                        check($sformatf("rnd%0d_mode", got), out_mode, x_mode[got]);
                        got++;
                        out_ready = 1'b1;
                        @(posedge clk); #1;
                        cyc++;
                        out_ready = 1'b0;
                    end
                end
                check("rnd_groups_seen", got, NG);
            end
        join

        // Nothing left over once the stream is drained
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("rnd_no_extra_group", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
